// File: rtl/denise_clut_writer.sv
// denise_clut_writer
//   Write scheduler for the 256 x 32-bit byte-enabled colour look-up table.
//   Three sources share the single CLUT write port, one issue per clk:
//     bus (COLORxx register writes) > host palette loader > clear sweep.
//   Every output is a flop, so the strobes are glitch-free. Reset is async.
// Ports:
//   clk, reset_n            28MHz clock, async active-low reset
//   clk7_en                 qualifies bus writes
//   reg_address_in/data_in  register bus (address bits [8:1], 12-bit RGB)
//   bank, loct              colour bank select and low-nibble-only flag
//   host_req/adr/rgb/ack    host palette write handshake (ack = 1 clk pulse)
//   clr_start, clr_busy     start/restart full-table clear, sweep active
//   wr_en/adr/dat/bs        CLUT write port
module denise_clut_writer #(
  parameter logic [8:0] COLORBASE = 9'h180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic [7:0]  reg_address_in,
  input  logic [11:0] data_in,
  input  logic [2:0]  bank,
  input  logic        loct,
  input  logic        host_req,
  input  logic [7:0]  host_adr,
  input  logic [23:0] host_rgb,
  output logic        host_ack,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        wr_en,
  output logic [7:0]  wr_adr,
  output logic [31:0] wr_dat,
  output logic [3:0]  wr_bs
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  typedef struct packed {
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  bs;
  } clut_wr_t;

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_en_q, wr_en_d;
  clut_wr_t   wr_q, wr_d;
  logic       host_ack_q, host_ack_d;
  logic       bus_hit, host_go, clr_go;

  always_comb begin
    // reg_address_in carries address bits [8:1], so [7:5] are bits [8:6]
    bus_hit = clk7_en && (reg_address_in[7:5] == COLORBASE[8:6]);
    // host_ack_q masks a request still held during its own ack cycle
    host_go = !bus_hit && host_req && !host_ack_q && (state_q == S_IDLE);
    // a restart pulse suppresses this clk's clear write so the sweep
    // resumes cleanly from index 0
    clr_go  = !bus_hit && (state_q == S_CLEAR) && !clr_start;

    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;      // data/address/enables hold when idle
    wr_en_d    = 1'b0;
    host_ack_d = 1'b0;

    if (bus_hit) begin
      wr_en_d = 1'b1;
      wr_d.adr = {bank, reg_address_in[4:0]};
      wr_d.dat = {4'h0, data_in, 4'h0, data_in};
      wr_d.bs  = loct ? 4'b0011 : 4'b1111;
    end else if (host_go) begin
      wr_en_d    = 1'b1;
      host_ack_d = 1'b1;
      wr_d.adr = host_adr;
      // high nibbles in the upper half-word, low nibbles in the lower
      wr_d.dat = {4'h0, host_rgb[23:20], host_rgb[15:12], host_rgb[7:4],
                  4'h0, host_rgb[19:16], host_rgb[11:8],  host_rgb[3:0]};
      wr_d.bs  = 4'b1111;
    end else if (clr_go) begin
      wr_en_d  = 1'b1;
      wr_d.adr = cnt_q;
      wr_d.dat = 32'h0;
      wr_d.bs  = 4'b1111;
      cnt_d    = cnt_q + 8'd1;
      if (cnt_q == 8'hFF) state_d = S_IDLE;
    end

    if (clr_start) begin
      state_d = S_CLEAR;
      cnt_d   = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_q       <= '0;
      host_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_q       <= wr_d;
      host_ack_q <= host_ack_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_adr   = wr_q.adr;
  assign wr_dat   = wr_q.dat;
  assign wr_bs    = wr_q.bs;
  assign host_ack = host_ack_q;
  assign clr_busy = (state_q == S_CLEAR);

endmodule

// File: doc/denise_clut_writer.md
# denise_clut_writer

Write scheduler for the Denise colour look-up table (256 × 32-bit, byte-enabled, single write port). It merges three write sources onto the one CLUT write port:
- chip-bus COLORxx register writes from the copper/CPU;
- a host palette loader with a req/ack handshake, used by the OSD/control CPU;
- a full-table clear sweep.

It sits between the register bus and the CLUT write port of the HAM/colour generator. It produces registered, glitch-free write strobes.

## Interface
Parameters:
- COLORBASE, 9'h180, base register address of the colour table (bits [8:6] decoded)

Ports:
- clk  in  1  28MHz clock
- reset_n  in  1  reset, asynchronous, active-low
- clk7_en  in  1  7MHz clock enable; bus writes are only valid when high
- reg_address_in  in  8  register address [8:1]
- data_in  in  12  bus write data (4-bit R,G,B)
- bank  in  3  colour bank select (BPLCON3)
- loct  in  1  1 = bus write targets the low nibbles only
- host_req  in  1  host palette write request
- host_adr  in  8  host CLUT index
- host_rgb  in  24  host colour, 8-bit R,G,B
- host_ack  out  1  one-clock pulse: the host write was issued
- clr_start  in  1  pulse: start (or restart) the clear sweep
- clr_busy  out  1  clear sweep in progress
- wr_en  out  1  CLUT write enable
- wr_adr  out  8  CLUT write address
- wr_dat  out  32  CLUT write data
- wr_bs  out  4  CLUT byte enables

## Operation
- All outputs are registered. Reset value of every output is 0. Internal FSM resets to IDLE, sweep counter to 0.
- Bus hit: `clk7_en && reg_address_in[8:6]==COLORBASE[8:6]`.
  - adr = {bank, reg_address_in[5:1]}
  - dat = {4'b0, data_in, 4'b0, data_in}
  - bs = loct ? 4'b0011 : 4'b1111
- Host eligible: `host_req && !host_ack && state==IDLE`. The host_ack term blocks re-sampling of a request that is still held in its ack cycle.
  - dat = {4'b0, R[7:4],G[7:4],B[7:4], 4'b0, R[3:0],G[3:0],B[3:0]}
  - bs = 4'b1111
- Clear write: state==CLEAR.
  - adr = cnt, dat = 0, bs = 4'b1111
- Priority per clk: bus > host > clear. Only one source is issued per clk.
  - A loser is never lost: the host keeps its request asserted; the clear counter holds.
- FSM states:
  - IDLE: clr_start → CLEAR, cnt=0.
  - CLEAR: on each clk where a clear write is issued, cnt++. When cnt==255 is issued → IDLE.
  - clr_start while in CLEAR: cnt=0, remain in CLEAR (restart).
- Host requests are not accepted while in CLEAR. host_ack stays 0 until the sweep ends.
- A bus write issued during CLEAR to an index ≥ cnt is overwritten later by the sweep. This is defined behaviour.
- Host protocol:
  - Host holds host_adr/host_rgb stable while host_req is high, until host_ack.
  - host_req still high in the cycle after the ack cycle is a new request.
  - Maximum host rate is one write per 2 clk.
- wr_en is low on every clk where nothing is issued. wr_adr/wr_dat/wr_bs hold their last values.

## Timing
- Latency: source sampled at edge E → wr_en/wr_adr/wr_dat/wr_bs valid for exactly one clk after E.
- host_ack is asserted in the same cycle as its wr_en.
- Bus writes are never delayed. Their rate is at most 1 per 4 clk (clk7_en), so there is always room for lower-priority sources.
- Clear, undisturbed:
  - clr_start sampled at E0 → clr_busy=1 from cycle 1.
  - adr 0..255 appear on wr_* in cycles 2..257.
  - clr_busy=0 from cycle 257, so it is high for exactly 256 cycles.
  - Each bus or host-blocked stall adds one cycle; each interleaved bus write extends the sweep by 1.
- Simultaneous bus hit and host request: bus issued at E, host at E+1, with host_ack at cycle E+2.
- reset_n low at any time, including mid-sweep or mid-handshake:
  - all outputs go to 0 immediately;
  - the sweep is aborted;
  - a pending host request is not acked and must be re-presented after reset.

## Test plan
- Bus write: reg_address_in=9'h182>>1, bank=3, loct=0, data_in=12'hABC, clk7_en=1 → next clk: wr_en=1, wr_adr=8'h61, wr_dat=32'h0ABC0ABC, wr_bs=4'hF. Repeat with loct=1 → wr_bs=4'h3. Same write with clk7_en=0 or address 9'h1C0 → wr_en stays 0.
- Host write: host_adr=8'h10, host_rgb=24'h123456 → one clk later: wr_en=1, wr_adr=8'h10, wr_dat=32'h01350246, host_ack=1 for one clk. host_req held high for 4 clk with the same data → exactly 2 writes/acks, 2 clk apart.
- Collision: bus hit and host_req at the same edge → bus write in cycle 1, host write + host_ack in cycle 2.
- Clear: clr_start pulse → clr_busy high 256 cycles; 256 writes, adr 0..255 ascending, dat=0, bs=4'hF. host_req during the sweep → no ack until clr_busy falls, then ack.
- Clear with 3 interleaved bus writes → all 3 bus writes appear; clr_busy high 259 cycles; no clear address skipped or duplicated. clr_start at cnt=100 → sweep restarts at adr 0.
- Reset at cnt=50 → all outputs 0 asynchronously. After release: wr_en=0, clr_busy=0 until a new clr_start.
